// File: rtl/hub75_shifter.sv
// HUB75 row shifter: reads one row of pixels per segment and shifts one bit plane out to the panel.
// Latency: first read 1 cycle after start; tx_ready low for 3 + 2*hpixel_p*(div+1) cycles.
// Backpressure: single-cycle start is accepted only while o_tx_ready=1; other starts are dropped.
module hub75_shifter #(
  parameter int hpixel_p   = 64,
  parameter int vpixel_p   = 64,
  parameter int bpp_p      = 8,
  parameter int segments_p = 2,
  localparam int addr_width_p    = $clog2(hpixel_p * vpixel_p),
  localparam int pix_bit_width_p = $clog2(bpp_p)
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [3:0]                       i_clk_div,
  input  logic                             i_tx_start,
  input  logic [addr_width_p-1:0]          i_init_addr,
  input  logic [pix_bit_width_p-1:0]       i_pix_bit,
  output logic                             o_tx_ready,
  output logic                             o_mem_en,
  output logic [addr_width_p-1:0]          o_mem_addr,
  input  logic [segments_p*3*bpp_p-1:0]    i_mem_data,
  output logic [3*segments_p-1:0]          o_rgb,
  output logic                             o_hub_clk,
  output logic                             o_row_done
);

  localparam int col_w = (hpixel_p > 1) ? $clog2(hpixel_p) : 1;
  localparam logic [col_w-1:0]        last_col = col_w'(hpixel_p - 1);
  localparam logic [col_w-1:0]        col_one  = 1;
  localparam logic [addr_width_p-1:0] addr_one = 1;

  typedef enum logic [2:0] {IDLE, FETCH, PRIME, LOW, HIGH, DONE} state_t;

  state_t                       state;
  logic [3:0]                   div_q;
  logic [3:0]                   phase_cnt;
  logic [pix_bit_width_p-1:0]   pix_q;
  logic [col_w-1:0]             col;
  logic                         rd_pend;   // read data is on i_mem_data this cycle
  logic [3*segments_p-1:0]      pf_rgb;    // prefetched bits for the next column
  logic [3*segments_p-1:0]      mem_bits;
  logic [3*segments_p-1:0]      next_rgb;

  // Pick the captured bit plane out of every channel of every segment.
  always_comb begin
    mem_bits = '0;
    for (int s = 0; s < segments_p; s++) begin
      mem_bits[3*s+2] = i_mem_data[s*3*bpp_p + 2*bpp_p + int'(pix_q)];
      mem_bits[3*s+1] = i_mem_data[s*3*bpp_p +   bpp_p + int'(pix_q)];
      mem_bits[3*s]   = i_mem_data[s*3*bpp_p +           int'(pix_q)];
    end
  end

  // With div=0 the read returns in the very cycle the column switches, so bypass the prefetch register.
  always_comb begin
    next_rgb = rd_pend ? mem_bits : pf_rgb;
  end

  // Row transfer FSM; the memory does not hold its data, so a prefetched word is parked in pf_rgb.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      o_tx_ready <= 1'b1;
      o_mem_en   <= 1'b0;
      o_mem_addr <= '0;
      o_rgb      <= '0;
      o_hub_clk  <= 1'b0;
      o_row_done <= 1'b0;
      div_q      <= '0;
      pix_q      <= '0;
      col        <= '0;
      phase_cnt  <= '0;
      rd_pend    <= 1'b0;
      pf_rgb     <= '0;
    end else begin
      rd_pend <= o_mem_en;
      if (rd_pend) pf_rgb <= mem_bits;
      case (state)
        IDLE: begin
          if (i_tx_start) begin
            div_q      <= i_clk_div;
            pix_q      <= i_pix_bit;
            o_mem_addr <= i_init_addr;
            col        <= '0;
            o_mem_en   <= 1'b1;
            o_tx_ready <= 1'b0;
            state      <= FETCH;
          end
        end
        FETCH: begin
          o_mem_en <= 1'b0;
          state    <= PRIME;
        end
        PRIME: begin
          o_rgb     <= mem_bits;
          phase_cnt <= '0;
          state     <= LOW;
          if (col != last_col) begin
            o_mem_en   <= 1'b1;
            o_mem_addr <= o_mem_addr + addr_one;
          end
        end
        LOW: begin
          o_mem_en <= 1'b0;
          if (phase_cnt == div_q) begin
            phase_cnt <= '0;
            o_hub_clk <= 1'b1;
            state     <= HIGH;
          end else begin
            phase_cnt <= phase_cnt + 4'd1;
          end
        end
        HIGH: begin
          if (phase_cnt == div_q) begin
            phase_cnt <= '0;
            o_hub_clk <= 1'b0;
            if (col != last_col) begin
              o_rgb <= next_rgb;
              col   <= col + col_one;
              state <= LOW;
              if ((col + col_one) != last_col) begin
                o_mem_en   <= 1'b1;
                o_mem_addr <= o_mem_addr + addr_one;
              end
            end else begin
              o_row_done <= 1'b1;
              state      <= DONE;
            end
          end else begin
            phase_cnt <= phase_cnt + 4'd1;
          end
        end
        DONE: begin
          o_row_done <= 1'b0;
          o_tx_ready <= 1'b1;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
